// File: rtl/shifter_pkg.sv
// Shared encodings for the multicycle shifter.
// Mode codes and the control state enum.
package shifter_pkg;

  localparam logic [1:0] SH_SLL = 2'b00;
  localparam logic [1:0] SH_SRL = 2'b01;
  localparam logic [1:0] SH_SRA = 2'b10;
  localparam logic [1:0] SH_ROR = 2'b11;

  typedef enum logic [1:0] {
    IDLE,
    SHIFT,
    DONE
  } state_t;

endpackage

// File: rtl/shift_step.sv
// One combinational shift step of 0..STEP positions.
// Rotate path only with MULTICYCLE_SHIFTER_ROTATE_EN.
module shift_step
  import shifter_pkg::*;
#(
  parameter int WIDTH = 16,
  parameter int STEP  = 4,
  parameter int AW    = $clog2(STEP + 1)
) (
  input  logic [WIDTH-1:0] data,
  input  logic [AW-1:0]    amt,
  input  logic [1:0]       mode,
  output logic [WIDTH-1:0] res
);

`ifdef MULTICYCLE_SHIFTER_ROTATE_EN
  logic [2*WIDTH-1:0] dbl;
  assign dbl = {data, data} >> amt;
`endif

  // Select the shifted operand for the latched mode.
  always_comb begin
    res = data >> amt;
    case (mode)
      SH_SLL: res = data << amt;
      SH_SRA: res = $unsigned($signed(data) >>> amt);
`ifdef MULTICYCLE_SHIFTER_ROTATE_EN
      SH_ROR: res = dbl[WIDTH-1:0];
`endif
      default: res = data >> amt;
    endcase
  end

endmodule

// File: rtl/multicycle_shifter.sv
// Iterative shifter, up to STEP bits per clock.
// Optional rotate: MULTICYCLE_SHIFTER_ROTATE_EN.
module multicycle_shifter
  import shifter_pkg::*;
#(
  parameter int WIDTH = 16,
  parameter int STEP  = 4,
  localparam int CNT_W = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  input  logic [CNT_W-1:0] in_cnt,
  input  logic [1:0]       in_mode,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data
);

  localparam int AW = $clog2(STEP + 1);

  state_t           state;
  logic [WIDTH-1:0] data;
  logic [CNT_W-1:0] rem;
  logic [1:0]       mode;
  logic [CNT_W:0]   s;
  logic [AW-1:0]    amt;
  logic [CNT_W-1:0] rem_nxt;
  logic [WIDTH-1:0] stepped;

  // Step size is min(STEP, rem); widened so STEP == WIDTH fits.
  always_comb begin
    s = {1'b0, rem};
    if ({1'b0, rem} > (CNT_W+1)'(STEP))
      s = (CNT_W+1)'(STEP);
    amt     = AW'(s);
    rem_nxt = rem - s[CNT_W-1:0];
  end

  shift_step #(
    .WIDTH (WIDTH),
    .STEP  (STEP)
  ) u_step (
    .data  (data),
    .amt   (amt),
    .mode  (mode),
    .res   (stepped)
  );

  assign in_ready = (state == IDLE);
  assign out_data = data;

  // Control FSM with the data register and remaining count.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      data      <= '0;
      rem       <= '0;
      mode      <= SH_SLL;
      out_valid <= 1'b0;
    end else begin
      unique case (state)
        IDLE: begin
          if (in_valid) begin
            data <= in_data;
            rem  <= in_cnt;
            mode <= in_mode;
            if (in_cnt != '0) begin
              state <= SHIFT;
            end else begin
              state     <= DONE;
              out_valid <= 1'b1;
            end
          end
        end
        SHIFT: begin
          data <= stepped;
          rem  <= rem_nxt;
          if (rem_nxt == '0) begin
            state     <= DONE;
            out_valid <= 1'b1;
          end
        end
        DONE: begin
          if (out_ready) begin
            state     <= IDLE;
            out_valid <= 1'b0;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: doc/multicycle_shifter.md
# multicycle_shifter

Parametrised, iterative shifter that performs logical-left, logical-right, arithmetic-right and (optionally) rotate-right shifts of a WIDTH-bit operand. It shifts up to STEP bit positions per clock and moves operands and results over valid/ready handshakes. It sits in the execute stage as a low-area alternative to the single-cycle 16-bit combinational arithmetic-right shifter. The pipeline stalls on in_ready/out_valid.

## Interface
- WIDTH, 16, operand/result width; power of two, >= 4.
- STEP, 4, maximum bit positions shifted per cycle; power of two, 1 <= STEP <= WIDTH.
- CNT_W (localparam), $clog2(WIDTH), width of the shift count.
- clk  in  1  single clock; all state updates on its rising edge.
- rst  in  1  asynchronous, active-high reset.
- in_valid  in  1  operand presented.
- in_ready  out  1  block can accept; high only in IDLE.
- in_data  in  WIDTH  operand.
- in_cnt  in  CNT_W  shift amount, 0..WIDTH-1.
- in_mode  in  2  00 SLL, 01 SRL, 10 SRA, 11 ROR (see Configuration).
- out_valid  out  1  result available; high only in DONE.
- out_ready  in  1  consumer takes result.
- out_data  out  WIDTH  result register.

## Operation
- States: IDLE, SHIFT, DONE.
- IDLE, on in_valid & in_ready:
  - Latch in_data into the data register, in_cnt into rem, and in_mode.
  - Next state is SHIFT if in_cnt != 0, else DONE.
- SHIFT, each edge:
  - s = min(STEP, rem). Shift data by s per the latched mode; rem <= rem - s.
  - When rem - s == 0, go to DONE.
- Per-step fill rules:
  - SLL: zero-fill from the LSB.
  - SRL: zero-fill from the MSB.
  - SRA: fill with the latched operand's bit WIDTH-1. The sign is preserved across steps because the fill always copies the current MSB.
  - ROR: bits shifted out of the LSB re-enter at the MSB.
- DONE: out_valid = 1 and out_data = data register, held stable until out_ready. On out_valid & out_ready, go to IDLE.
- in_ready is low in SHIFT and DONE. There is no overlap between a result handshake and a new accept in the same cycle.
- in_valid/in_data are ignored outside IDLE. in_cnt >= WIDTH cannot occur because the count is CNT_W bits wide.
- Reset, including mid-SHIFT or mid-DONE: state IDLE, in_ready 1, out_valid 0, out_data 0, rem 0. The in-flight operation is discarded and no result is produced.

## Timing
- n = ceil(in_cnt / STEP).
- out_valid rises n edges after the accept edge. For in_cnt = 0 it rises on the accept edge itself, i.e. visible the next cycle.
- Minimum occupancy per operation: accept cycle + n SHIFT cycles + 1 DONE cycle.
- Example, WIDTH=16, STEP=4, cnt=15: 4 SHIFT cycles. The last step uses s=3.
- With STEP=WIDTH, every nonzero count completes in exactly 1 SHIFT cycle.
- out_data is registered. No input combinationally reaches any output except via state.

## Configuration
- MULTICYCLE_SHIFTER_ROTATE_EN:
  - Defined: mode 11 performs ROR.
  - Undefined: the rotate path is not built and mode 11 executes as SRL.

## Structure
- Package shifter_pkg holds:
  - Mode encodings SH_SLL=2'b00, SH_SRL=2'b01, SH_SRA=2'b10, SH_ROR=2'b11.
  - The state enum (IDLE, SHIFT, DONE).
- One sub-module, shift_step: combinational, parametrised by WIDTH and STEP. It shifts by 0..STEP positions per mode and is instantiated once.
- The top level owns the FSM, the rem counter and the data register.

## Test plan
All scenarios use WIDTH=16, STEP=4.
- SRA, data 16'h8000, cnt 15 -> out_data 16'hFFFF; out_valid 4 edges after accept.
- SRL, data 16'h8000, cnt 15 -> 16'h0001. SLL, data 16'h00F1, cnt 5 -> 16'h1E20, after 2 SHIFT cycles.
- SLL, data 16'h0001, cnt 0 -> 16'h0001; out_valid on the cycle after accept; no SHIFT state entered.
- Backpressure:
  - Hold out_ready low 5 cycles in DONE -> out_data and out_valid stable; in_ready 0; a second in_valid is not accepted.
  - Raise out_ready -> IDLE next cycle, and the next operand is accepted.
- Reset pulse mid-SHIFT (SRA, cnt 12, after 1 step) -> out_valid 0, out_data 0, in_ready 1 immediately (async). No result is ever emitted.
- ROR, data 16'h1234, cnt 4 -> 16'h4123 with MULTICYCLE_SHIFTER_ROTATE_EN defined; 16'h0123 without it.
